// File: rtl/sap1_pkg.sv
// +----------------------------------------------------------------------+
// | sap1_pkg -- shared SAP-1 datapath constants and types (Rev 1.0)      |
// +----------------------------------------------------------------------+
`default_nettype none

package sap1_pkg;

  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RESET_ADDR = '0;

endpackage

`default_nettype wire

// File: rtl/mar_if.sv
// +----------------------------------------------------------------------+
// | mar_if -- bus between controller/W bus and MAR; inc under MAR_INC_EN |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mar_if #(
  parameter int ADDR_W = 4
);

  logic              load;
  logic [ADDR_W-1:0] D;
  logic [ADDR_W-1:0] Q;
`ifdef MAR_INC_EN
  logic              inc;
`endif

  modport master (
    output load,
    output D,
`ifdef MAR_INC_EN
    output inc,
`endif
    input  Q
  );

  modport slave (
    input  load,
    input  D,
`ifdef MAR_INC_EN
    input  inc,
`endif
    output Q
  );

endinterface

`default_nettype wire

// File: rtl/sap_reg.sv
// +----------------------------------------------------------------------+
// | sap_reg -- parameterised enable flop with async active-high clear    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sap_reg #(
  parameter int          W         = 4,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  wire logic         clk_i,
  input  wire logic         clr_i,
  input  wire logic         en_i,
  input  wire logic [W-1:0] d_i,
  output      logic [W-1:0] q_o
);

  logic [W-1:0] r_q_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      r_q_q <= RESET_VAL;
    end else if (en_i) begin
      r_q_q <= d_i;
    end
  end

  assign q_o = r_q_q;

endmodule

`default_nettype wire

// File: rtl/mar.sv
// +----------------------------------------------------------------------+
// | mar -- SAP-1 memory address register; MAR_INC_EN adds wrap increment |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mar #(
  parameter int                ADDR_W    = sap1_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VAL = sap1_pkg::RESET_ADDR
) (
  input wire logic CLK,
  input wire logic CLR,
  mar_if.slave     bus
);

  import sap1_pkg::*;

  logic              w_en_d;
  logic [ADDR_W-1:0] w_addr_d;
  logic [ADDR_W-1:0] w_addr_q;

`ifdef MAR_INC_EN
  localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  // load wins over inc; the add wraps naturally at ADDR_W bits
  always_comb begin
    w_en_d   = bus.load | bus.inc;
    w_addr_d = bus.load ? bus.D : (w_addr_q + c_one);
  end
`else
  always_comb begin
    w_en_d   = bus.load;
    w_addr_d = bus.D;
  end
`endif

  sap_reg #(
    .W         (ADDR_W),
    .RESET_VAL (RESET_VAL)
  ) u_addr_reg (
    .clk_i (CLK),
    .clr_i (CLR),
    .en_i  (w_en_d),
    .d_i   (w_addr_d),
    .q_o   (w_addr_q)
  );

  assign bus.Q = w_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mar.sv
// +----------------------------------------------------------------------+
// | tb_mar -- directed self-checking bench for mar                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mar;

  logic CLK;
  logic CLR;
  int   n_total;
  int   n_bad;

  mar_if #(.ADDR_W(4)) bus ();

  mar #(.ADDR_W(4), .RESET_VAL(4'h0)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] cnt;
  logic [3:0] exp_q;

  initial begin
    n_total = 0;
    n_bad   = 0;
`ifdef MAR_INC_EN
    bus.inc = 1'b0;
`endif
    // reset asserted with a pending load
    CLR      = 1'b1;
    bus.load = 1'b1;
    bus.D    = 4'hA;
    #2;
    check_eq("reset_async", bus.Q, 4'h0);
    tick();
    check_eq("reset_hold1", bus.Q, 4'h0);
    tick();
    check_eq("reset_hold2", bus.Q, 4'h0);
    CLR = 1'b0;
    tick();
    check_eq("reset_release_load", bus.Q, 4'hA);

    // hold with D changing
    bus.D = 4'h7;
    tick();
    check_eq("load_7", bus.Q, 4'h7);
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.D = 4'(i);
      tick();
      check_eq("hold", bus.Q, 4'h7);
    end

    // burst load
    bus.load = 1'b1;
    bus.D = 4'h5; tick(); check_eq("burst_5", bus.Q, 4'h5);
    bus.D = 4'h6; tick(); check_eq("burst_6", bus.Q, 4'h6);
    bus.D = 4'h7; tick(); check_eq("burst_7", bus.Q, 4'h7);
    bus.load = 1'b0;
    bus.D = 4'h9; tick(); check_eq("burst_after", bus.Q, 4'h7);

    // no combinational path from D/load to Q
    bus.load = 1'b1;
    bus.D    = 4'hB;
    #2;
    check_eq("no_comb_path", bus.Q, 4'h7);
    bus.D = 4'hC;
    tick();
    check_eq("last_d_at_edge", bus.Q, 4'hC);

    // periodic strobe: 3 load cycles, 6 idle, D free-running
    cnt   = 4'h0;
    exp_q = 4'hC;
    for (int rep = 0; rep < 50; rep++) begin
      for (int c = 0; c < 9; c++) begin
        bus.load = (c < 3);
        bus.D    = cnt;
        tick();
        if (c < 3) exp_q = cnt;
        cnt = cnt + 4'h1;
        if (c == 2) check_eq("periodic_burst", bus.Q, exp_q);
        if (c == 8) check_eq("periodic_idle", bus.Q, exp_q);
      end
    end

`ifdef MAR_INC_EN
    bus.load = 1'b1;
    bus.D    = 4'hE;
    tick();
    check_eq("inc_seed", bus.Q, 4'hE);
    bus.load = 1'b0;
    bus.inc  = 1'b1;
    tick(); check_eq("inc_F", bus.Q, 4'hF);
    tick(); check_eq("inc_wrap0", bus.Q, 4'h0);
    tick(); check_eq("inc_1", bus.Q, 4'h1);
    bus.load = 1'b1;
    bus.D    = 4'h3;
    tick(); check_eq("load_over_inc", bus.Q, 4'h3);
    bus.inc  = 1'b0;
    bus.load = 1'b0;
    tick(); check_eq("inc_off_hold", bus.Q, 4'h3);
`endif

    // clear in the middle of a load burst
    bus.load = 1'b1;
    bus.D    = 4'h4;
    tick();
    check_eq("pre_clear_load", bus.Q, 4'h4);
    bus.D = 4'h5;
    #2;
    CLR = 1'b1;
    #1;
    check_eq("mid_clear_async", bus.Q, 4'h0);
    tick();
    check_eq("clear_no_update1", bus.Q, 4'h0);
    bus.D = 4'h8;
    tick();
    check_eq("clear_no_update2", bus.Q, 4'h0);
    CLR   = 1'b0;
    bus.D = 4'h6;
    tick();
    check_eq("resume_load_6", bus.Q, 4'h6);
    bus.D = 4'h2;
    tick();
    check_eq("resume_load_2", bus.Q, 4'h2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
